// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the multi-cycle CPU controller: states, opcodes,
// ALU operation and operand-select codes, and the packed control word.
package cpu_ctrl_pkg;

    localparam int OP_W    = 6;
    localparam int STATE_W = 4;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_R_EXEC   = 4'd6,
        S_R_WB     = 4'd7,
        S_BRANCH   = 4'd8,
        S_JUMP     = 4'd9,
        S_I_EXEC   = 4'd10,
        S_I_WB     = 4'd11
    } state_t;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
    localparam logic [OP_W-1:0] OP_LW    = 6'h23;
    localparam logic [OP_W-1:0] OP_SW    = 6'h2B;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
    localparam logic [OP_W-1:0] OP_J     = 6'h02;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;
    localparam logic [OP_W-1:0] OP_SLTI  = 6'h0A;

    localparam logic [2:0] ALUOP_ADD   = 3'd0;
    localparam logic [2:0] ALUOP_SUB   = 3'd1;
    localparam logic [2:0] ALUOP_RTYPE = 3'd2;
    localparam logic [2:0] ALUOP_SLT   = 3'd3;

    localparam logic [1:0] ALUB_RT     = 2'd0;
    localparam logic [1:0] ALUB_FOUR   = 2'd1;
    localparam logic [1:0] ALUB_IMM    = 2'd2;
    localparam logic [1:0] ALUB_IMM_SH = 2'd3;

    localparam logic [1:0] PCSRC_ALU    = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic [1:0] pc_source;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic       retire;
        logic       illegal;
    } ctrl_word_t;

    function automatic logic is_legal_op(input logic [OP_W-1:0] op);
        logic legal;
        case (op)
            OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI, OP_SLTI: legal = 1'b1;
            default:                                                 legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/ctrl_out_decode.sv
// Combinational decode of the controller state (plus memory handshake and
// opcode where a state needs them) into the datapath control word.
module ctrl_out_decode
    import cpu_ctrl_pkg::*;
(
    input  state_t             state,
    input  logic               mem_ready,
    input  logic [OP_W-1:0]    op_code,
    output ctrl_word_t         ctrl
);

    // Control word decode; every field not named in a state stays 0.
    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.i_or_d    = 1'b0;
                ctrl.alu_src_a = 1'b0;
                ctrl.alu_src_b = ALUB_FOUR;
                ctrl.alu_op    = ALUOP_ADD;
                ctrl.pc_source = PCSRC_ALU;
                if (mem_ready) begin
                    ctrl.ir_write = 1'b1;
                    ctrl.pc_write = 1'b1;
                end else begin
                    ctrl.ir_write = 1'b0;
                    ctrl.pc_write = 1'b0;
                end
            end
            S_DECODE: begin
                ctrl.alu_src_a = 1'b0;
                ctrl.alu_src_b = ALUB_IMM_SH;
                ctrl.alu_op    = ALUOP_ADD;
                if (!is_legal_op(op_code)) begin
                    ctrl.illegal = 1'b1;
                    ctrl.retire  = 1'b1;
                end else begin
                    ctrl.illegal = 1'b0;
                    ctrl.retire  = 1'b0;
                end
            end
            S_MEM_ADDR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = ALUB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_MEM_RD: begin
                ctrl.mem_read = 1'b1;
                ctrl.i_or_d   = 1'b1;
            end
            S_MEM_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.reg_dst    = 1'b0;
                ctrl.retire     = 1'b1;
            end
            S_MEM_WR: begin
                ctrl.mem_write = 1'b1;
                ctrl.i_or_d    = 1'b1;
                ctrl.retire    = mem_ready;
            end
            S_R_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = ALUB_RT;
                ctrl.alu_op    = ALUOP_RTYPE;
            end
            S_R_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = 1'b1;
                ctrl.mem_to_reg = 1'b0;
                ctrl.retire     = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = ALUB_RT;
                ctrl.alu_op        = ALUOP_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PCSRC_ALUOUT;
                ctrl.retire        = 1'b1;
            end
            S_JUMP: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PCSRC_JUMP;
                ctrl.retire    = 1'b1;
            end
            S_I_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = ALUB_IMM;
                ctrl.alu_op    = (op_code == OP_SLTI) ? ALUOP_SLT : ALUOP_ADD;
            end
            S_I_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = 1'b0;
                ctrl.mem_to_reg = 1'b0;
                ctrl.retire     = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle CPU control FSM: holds the state register and next-state logic,
// and forces a safe fetch-read-only control word while reset is applied.
module multi_cycle_ctrl
    import cpu_ctrl_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [OP_W-1:0]    op_code_i,
    input  logic               zero_i,
    input  logic               mem_ready_i,
    output logic               pc_write_o,
    output logic               pc_write_cond_o,
    output logic [1:0]         pc_source_o,
    output logic               i_or_d_o,
    output logic               mem_read_o,
    output logic               mem_write_o,
    output logic               ir_write_o,
    output logic               mem_to_reg_o,
    output logic               reg_dst_o,
    output logic               reg_write_o,
    output logic               alu_src_a_o,
    output logic [1:0]         alu_src_b_o,
    output logic [2:0]         alu_op_o,
    output logic               retire_o,
    output logic               illegal_o,
    output logic [STATE_W-1:0] state_o
);

    state_t     state;
    state_t     next_state;
    ctrl_word_t ctrl_dec;
    ctrl_word_t ctrl_out;
    logic       zero_unused;

    // The branch condition is applied in the datapath via pc_write_cond.
    assign zero_unused = zero_i;

    ctrl_out_decode u_decode (
        .state     (state),
        .mem_ready (mem_ready_i),
        .op_code   (op_code_i),
        .ctrl      (ctrl_dec)
    );

    // State register with asynchronous return to FETCH.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= S_FETCH;
        end else begin
            state <= next_state;
        end
    end

    // Next-state sequencing; memory states hold until the access completes.
    always_comb begin
        next_state = S_FETCH;
        case (state)
            S_FETCH: begin
                if (mem_ready_i) next_state = S_DECODE;
                else             next_state = S_FETCH;
            end
            S_DECODE: begin
                case (op_code_i)
                    OP_RTYPE:         next_state = S_R_EXEC;
                    OP_LW, OP_SW:     next_state = S_MEM_ADDR;
                    OP_BEQ:           next_state = S_BRANCH;
                    OP_J:             next_state = S_JUMP;
                    OP_ADDI, OP_SLTI: next_state = S_I_EXEC;
                    default:          next_state = S_FETCH;
                endcase
            end
            S_MEM_ADDR: begin
                if (op_code_i == OP_SW)      next_state = S_MEM_WR;
                else if (op_code_i == OP_LW) next_state = S_MEM_RD;
                else                         next_state = S_FETCH;
            end
            S_MEM_RD: begin
                if (mem_ready_i) next_state = S_MEM_WB;
                else             next_state = S_MEM_RD;
            end
            S_MEM_WR: begin
                if (mem_ready_i) next_state = S_FETCH;
                else             next_state = S_MEM_WR;
            end
            S_R_EXEC: next_state = S_R_WB;
            S_I_EXEC: next_state = S_I_WB;
            S_MEM_WB, S_R_WB, S_I_WB, S_BRANCH, S_JUMP: next_state = S_FETCH;
            default:  next_state = S_FETCH;
        endcase
    end

    // During reset only the instruction-fetch read request is presented.
    always_comb begin
        ctrl_out = '0;
        if (rst_i) begin
            ctrl_out.mem_read = 1'b1;
        end else begin
            ctrl_out = ctrl_dec;
        end
    end

    assign pc_write_o      = ctrl_out.pc_write;
    assign pc_write_cond_o = ctrl_out.pc_write_cond;
    assign pc_source_o     = ctrl_out.pc_source;
    assign i_or_d_o        = ctrl_out.i_or_d;
    assign mem_read_o      = ctrl_out.mem_read;
    assign mem_write_o     = ctrl_out.mem_write;
    assign ir_write_o      = ctrl_out.ir_write;
    assign mem_to_reg_o    = ctrl_out.mem_to_reg;
    assign reg_dst_o       = ctrl_out.reg_dst;
    assign reg_write_o     = ctrl_out.reg_write;
    assign alu_src_a_o     = ctrl_out.alu_src_a;
    assign alu_src_b_o     = ctrl_out.alu_src_b;
    assign alu_op_o        = ctrl_out.alu_op;
    assign retire_o        = ctrl_out.retire;
    assign illegal_o       = ctrl_out.illegal;
    assign state_o         = state;

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Directed bench for multi_cycle_ctrl: an instruction-path model predicts the
// state and control word every cycle, plus hand-computed spot checks.
module tb_multi_cycle_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] op  = 6'h00;
    logic       rdy = 1'b1;
    logic       zero = 1'b0;

    logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic       mem_to_reg, reg_dst, reg_write, alu_src_a, retire, illegal;
    logic [1:0] pc_source, alu_src_b;
    logic [2:0] alu_op;
    logic [3:0] state_o;

    int n_checks = 0;
    int n_fail   = 0;
    int m_state  = 0;
    int m_q[$];
    bit chk_en   = 1'b0;

    always #5 clk = ~clk;

    multi_cycle_ctrl dut (
        .clk_i(clk), .rst_i(rst), .op_code_i(op), .zero_i(zero), .mem_ready_i(rdy),
        .pc_write_o(pc_write), .pc_write_cond_o(pc_write_cond), .pc_source_o(pc_source),
        .i_or_d_o(i_or_d), .mem_read_o(mem_read), .mem_write_o(mem_write),
        .ir_write_o(ir_write), .mem_to_reg_o(mem_to_reg), .reg_dst_o(reg_dst),
        .reg_write_o(reg_write), .alu_src_a_o(alu_src_a), .alu_src_b_o(alu_src_b),
        .alu_op_o(alu_op), .retire_o(retire), .illegal_o(illegal), .state_o(state_o)
    );

    wire [18:0] dut_word = {pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write,
                            ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b,
                            alu_op, retire, illegal};

    // Expected control word straight from the per-state rules.
    function automatic logic [18:0] exp_word(input int s, input logic r, input logic [5:0] o,
                                             input logic in_rst);
        logic pcw, pcwc, iod, mr, mw, irw, m2r, rd, rw, asa, ret, ill;
        logic [1:0] psrc, asb;
        logic [2:0] aop;
        {pcw, pcwc, iod, mr, mw, irw, m2r, rd, rw, asa, ret, ill} = 12'd0;
        psrc = 2'd0; asb = 2'd0; aop = 3'd0;
        if (in_rst) mr = 1'b1;
        else begin
            case (s)
                0:  begin mr = 1'b1; asb = 2'd1; irw = r; pcw = r; end
                1:  begin
                        asb = 2'd3;
                        if (!(o inside {6'h00, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h08, 6'h0A})) begin
                            ill = 1'b1; ret = 1'b1;
                        end
                    end
                2:  begin asa = 1'b1; asb = 2'd2; end
                3:  begin mr = 1'b1; iod = 1'b1; end
                4:  begin rw = 1'b1; m2r = 1'b1; ret = 1'b1; end
                5:  begin mw = 1'b1; iod = 1'b1; ret = r; end
                6:  begin asa = 1'b1; aop = 3'd2; end
                7:  begin rw = 1'b1; rd = 1'b1; ret = 1'b1; end
                8:  begin asa = 1'b1; aop = 3'd1; pcwc = 1'b1; psrc = 2'd1; ret = 1'b1; end
                9:  begin pcw = 1'b1; psrc = 2'd2; ret = 1'b1; end
                10: begin asa = 1'b1; asb = 2'd2; aop = (o == 6'h0A) ? 3'd3 : 3'd0; end
                11: begin rw = 1'b1; ret = 1'b1; end
                default: ;
            endcase
        end
        return {pcw, pcwc, psrc, iod, mr, mw, irw, m2r, rd, rw, asa, asb, aop, ret, ill};
    endfunction

    // Path of states an instruction visits after FETCH, by opcode.
    task automatic load_path(input logic [5:0] o);
        m_q.delete();
        m_q.push_back(1);
        case (o)
            6'h00:        begin m_q.push_back(6); m_q.push_back(7); end
            6'h23:        begin m_q.push_back(2); m_q.push_back(3); m_q.push_back(4); end
            6'h2B:        begin m_q.push_back(2); m_q.push_back(5); end
            6'h04:        m_q.push_back(8);
            6'h02:        m_q.push_back(9);
            6'h08, 6'h0A: begin m_q.push_back(10); m_q.push_back(11); end
            default:      ;
        endcase
    endtask

    task automatic model_step();
        if (rst) begin
            m_state = 0; m_q.delete();
        end else if ((m_state == 0 || m_state == 3 || m_state == 5) && !rdy) begin
            m_state = m_state;
        end else if (m_q.size() > 0) begin
            m_state = m_q.pop_front();
        end else if (m_state == 0) begin
            load_path(op); m_state = m_q.pop_front();
        end else begin
            m_state = 0;
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Set inputs for this cycle and confirm the state by hand expectation.
    task automatic set_in(input logic [5:0] o, input logic r, input int s_now);
        op = o; rdy = r;
        #1;
        chk("state_seq", int'(state_o), s_now);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                n_checks++;
                if (int'(state_o) != m_state) begin
                    n_fail++;
                    $display("FAIL model_state: got %0d expected %0d at %0t", state_o, m_state, $time);
                end
                n_checks++;
                if (dut_word !== exp_word(m_state, rdy, op, rst)) begin
                    n_fail++;
                    $display("FAIL model_ctrl: got %h expected %h state %0d at %0t",
                             dut_word, exp_word(m_state, rdy, op, rst), m_state, $time);
                end
                n_checks++;
                if (mem_read && mem_write) begin
                    n_fail++;
                    $display("FAIL mem_excl: read=%0b write=%0b, both high", mem_read, mem_write);
                end
            end
        end
    end

    initial begin
        chk_en = 1'b1;
        repeat (3) tick();
        chk("reset_state", int'(state_o), 0);
        chk("reset_word", int'(dut_word), 32'h0000_2000);
        rst = 1'b0;

        // R-type: 0,1,6,7,0
        set_in(6'h00, 1'b1, 0); chk("r_irw", int'(ir_write), 1); tick();
        set_in(6'h00, 1'b1, 1); tick();
        set_in(6'h00, 1'b1, 6); chk("r_aluop", int'(alu_op), 2); chk("r_exec_rd", int'(reg_dst), 0); tick();
        set_in(6'h00, 1'b1, 7); chk("r_rd", int'(reg_dst), 1); chk("r_ret", int'(retire), 1); tick();

        // lw with two wait cycles in MEM_RD
        set_in(6'h23, 1'b1, 0); tick();
        set_in(6'h23, 1'b1, 1); tick();
        set_in(6'h23, 1'b1, 2); chk("lw_asb", int'(alu_src_b), 2); tick();
        set_in(6'h23, 1'b0, 3); chk("lw_iod", int'(i_or_d), 1); chk("lw_wait_ret", int'(retire), 0); tick();
        set_in(6'h23, 1'b0, 3); tick();
        set_in(6'h23, 1'b1, 3); tick();
        set_in(6'h23, 1'b1, 4); chk("lw_rw", int'(reg_write), 1); chk("lw_m2r", int'(mem_to_reg), 1); tick();

        // sw, ready immediately
        set_in(6'h2B, 1'b1, 0); tick();
        set_in(6'h2B, 1'b1, 1); tick();
        set_in(6'h2B, 1'b1, 2); chk("sw_mw_early", int'(mem_write), 0); tick();
        set_in(6'h2B, 1'b1, 5); chk("sw_mw", int'(mem_write), 1); chk("sw_iod", int'(i_or_d), 1);
        chk("sw_ret", int'(retire), 1); tick();

        // beq
        set_in(6'h04, 1'b1, 0); chk("sw_mw_after", int'(mem_write), 0); tick();
        set_in(6'h04, 1'b1, 1); tick();
        set_in(6'h04, 1'b1, 8); chk("beq_pwc", int'(pc_write_cond), 1);
        chk("beq_psrc", int'(pc_source), 1); chk("beq_aluop", int'(alu_op), 1); tick();

        // j
        set_in(6'h02, 1'b1, 0); tick();
        set_in(6'h02, 1'b1, 1); tick();
        set_in(6'h02, 1'b1, 9); chk("j_pcw", int'(pc_write), 1); chk("j_psrc", int'(pc_source), 2); tick();

        // slti then addi
        set_in(6'h0A, 1'b1, 0); tick();
        set_in(6'h0A, 1'b1, 1); tick();
        set_in(6'h0A, 1'b1, 10); chk("slti_aluop", int'(alu_op), 3); tick();
        set_in(6'h0A, 1'b1, 11); chk("slti_rw", int'(reg_write), 1); tick();
        set_in(6'h08, 1'b1, 0); tick();
        set_in(6'h08, 1'b1, 1); tick();
        set_in(6'h08, 1'b1, 10); chk("addi_aluop", int'(alu_op), 0); tick();
        set_in(6'h08, 1'b1, 11); chk("addi_rd", int'(reg_dst), 0); tick();

        // illegal opcode
        set_in(6'h3F, 1'b1, 0); tick();
        set_in(6'h3F, 1'b1, 1); chk("ill_pulse", int'(illegal), 1); chk("ill_ret", int'(retire), 1);
        chk("ill_rw", int'(reg_write), 0); tick();
        set_in(6'h3F, 1'b0, 0); chk("ill_clear", int'(illegal), 0); chk("stall_irw", int'(ir_write), 0);
        chk("stall_pcw", int'(pc_write), 0); tick();
        set_in(6'h2B, 1'b0, 0); tick();

        // sw stalled in MEM_WR, then reset between clock edges
        set_in(6'h2B, 1'b1, 0); tick();
        set_in(6'h2B, 1'b1, 1); tick();
        set_in(6'h2B, 1'b1, 2); tick();
        set_in(6'h2B, 1'b0, 5); chk("mwr_hold", int'(mem_write), 1); chk("mwr_wait_ret", int'(retire), 0);
        rst = 1'b1; m_state = 0; m_q.delete();
        #1;
        chk("rst_mw_drop", int'(mem_write), 0);
        chk("rst_state", int'(state_o), 0);
        chk("rst_mr", int'(mem_read), 1);
        tick();
        rst = 1'b0;
        set_in(6'h00, 1'b1, 0); tick();
        set_in(6'h00, 1'b1, 1); tick();
        set_in(6'h00, 1'b1, 6); tick();
        set_in(6'h00, 1'b1, 7); chk("resume_ret", int'(retire), 1); tick();
        set_in(6'h00, 1'b0, 0);
        @(negedge clk);
        #1;
        chk_en = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
